// File: rtl/div_pkg.sv
// Shared constants, state encoding and counter sizing for the sequential divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_e;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, then keep R - |B| when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH:0]   r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] trial;
    logic             fits;

    always_comb begin
        r_sh  = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
        trial = {1'b0, r_sh} - {2'b00, mag_b};
        // A set top bit of R means the shifted value already exceeds any divisor.
        fits  = r_in[WIDTH] | ~trial[WIDTH+1];
        if (fits) begin
            r_out = trial[WIDTH:0];
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            r_out = r_sh;
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_seq.sv
// Sequential signed restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Define DIV_SELFCHECK_EN to compile a simulation-only result check at done.
module divider_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quo,
    output logic [WIDTH-1:0]     rem,
    output logic                 div_zero,
    output logic                 ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] Q_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e           state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     mag_b_q, mag_b_d;
    logic [WIDTH:0]       r_q, r_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 div_zero_q, div_zero_d;
    logic                 ovf_q, ovf_d;

    logic                 sign_a, sign_b, neg;
    logic [2*WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       r_nxt;
    logic [WIDTH-1:0]     q_nxt;

    assign sign_a = a_q[2*WIDTH-1];
    assign sign_b = b_q[WIDTH-1];
    assign neg    = sign_a ^ sign_b;
    // Negating the most negative dividend wraps to 2^(2W-1), which is the correct magnitude.
    assign mag_a  = sign_a ? -a_q : a_q;
    assign mag_b  = sign_b ? -b_q : b_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_q),
        .q_in  (q_q),
        .mag_b (mag_b_q),
        .r_out (r_nxt),
        .q_out (q_nxt)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mag_b_d    = mag_b_q;
        r_d        = r_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d        = A;
                    b_d        = B;
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = PREP;
                end
            end
            PREP: begin
                mag_b_d = mag_b;
                if (b_q == '0) begin
                    div_zero_d = 1'b1;
                    state_d    = FIX;
                end else if (mag_a[2*WIDTH-1:WIDTH] >= mag_b) begin
                    ovf_d   = 1'b1;
                    state_d = FIX;
                end else begin
                    r_d     = {1'b0, mag_a[2*WIDTH-1:WIDTH]};
                    q_d     = mag_a[WIDTH-1:0];
                    cnt_d   = CW'(WIDTH-1);
                    state_d = ITER;
                end
            end
            ITER: begin
                r_d = r_nxt;
                q_d = q_nxt;
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            FIX: begin
                quo_d   = '0;
                rem_d   = '0;
                state_d = DONE;
                if (!div_zero_q && !ovf_q) begin
                    if ((neg && q_q > Q_NEG_MAX) || (!neg && q_q > Q_POS_MAX)) begin
                        ovf_d = 1'b1;
                    end else begin
                        quo_d = neg ? -q_q : q_q;
                        rem_d = sign_a ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            mag_b_q    <= '0;
            r_q        <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mag_b_q    <= mag_b_d;
            r_q        <= r_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign quo      = quo_q;
    assign rem      = rem_q;
    assign div_zero = div_zero_q;
    assign ovf      = ovf_q;

`ifdef DIV_SELFCHECK_EN
    always @(posedge clk) begin
        if (done && !div_zero_q && !ovf_q) begin
            if ((longint'($signed(quo_q)) * longint'($signed(b_q)) + longint'($signed(rem_q)))
                    != longint'($signed(a_q)) ||
                (rem_q != '0 && !(longint'(sign_a ? -r_q[WIDTH-1:0] : rem_q) < longint'(mag_b_q)))) begin
                $display("divider_seq selfcheck: A=%0d B=%0d quo=%0d rem=%0d",
                         $signed(a_q), $signed(b_q), $signed(quo_q), $signed(rem_q));
                $error("divider_seq result inconsistent");
            end
        end
    end
`endif

endmodule
